// File: rtl/router_pkg.sv
// Shared mesh-router definitions: port directions, indices, flit width and
// the output-stage state encoding.
package router_pkg;

  localparam int NUM_PORTS = 5;
  localparam int FLIT_W    = 64;

  // One-hot direction codes, same bit order as the request vectors
  localparam logic [NUM_PORTS-1:0] DIR_L  = 5'b10000;
  localparam logic [NUM_PORTS-1:0] DIR_R  = 5'b01000;
  localparam logic [NUM_PORTS-1:0] DIR_U  = 5'b00100;
  localparam logic [NUM_PORTS-1:0] DIR_D  = 5'b00010;
  localparam logic [NUM_PORTS-1:0] DIR_PE = 5'b00001;

  localparam logic [2:0] IDX_L  = 3'd4;
  localparam logic [2:0] IDX_R  = 3'd3;
  localparam logic [2:0] IDX_U  = 3'd2;
  localparam logic [2:0] IDX_D  = 3'd1;
  localparam logic [2:0] IDX_PE = 3'd0;

  typedef enum logic {ST_EMPTY, ST_HOLD} oc_state_e;

  // Index of the set bit in a one-hot direction code (0 if none set)
  function automatic logic [2:0] onehot_idx(input logic [NUM_PORTS-1:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // (base + off) mod NUM_PORTS, used to walk the round-robin search order
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int unsigned off);
    int unsigned s;
    s = {29'b0, base} + off;
    return 3'(s % NUM_PORTS);
  endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Five-way round-robin arbiter. Search starts one past the most recently
// served port and wraps; purely combinational.
module rr_arbiter5
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [2:0]           last,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] grant,
  output logic [2:0]           grant_idx
);

  logic       found;
  logic [2:0] idx;

  // First requester at (last+1), (last+2), ... wrapping back to last itself
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = wrap_idx(last, i);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/output_ctrl.sv
// Per-output-port stage: round-robin among the five input sides, one-entry
// output buffer, one-cycle clear back to the winner, so/ro handshake out.
module output_ctrl
  import router_pkg::*;
#(
  parameter int                   DATA_WIDTH    = FLIT_W,
  parameter logic [NUM_PORTS-1:0] OUT_DIRECTION = DIR_PE,
  parameter int                   CNT_WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i,
  output logic [NUM_PORTS-1:0]            clear_o,
  output logic                            so,
  input  logic                            ro,
  output logic [DATA_WIDTH-1:0]           datao,
  output logic                            uturn_err,
  output logic [CNT_WIDTH-1:0]            flit_cnt
);

  // PE may legitimately loop back to itself; every other direction may not
  localparam logic [2:0] OUT_IDX     = onehot_idx(OUT_DIRECTION);
  localparam bit         CHECK_UTURN = (OUT_DIRECTION != DIR_PE);

  oc_state_e                              state;
  logic [2:0]                             last;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   slices;
  logic                                   can_load;
  logic                                   arb_en;
  logic                                   xfer;
  logic [NUM_PORTS-1:0]                   grant;
  logic [2:0]                             grant_idx;

  assign slices   = data_i;
  assign so       = (state == ST_HOLD);
  assign xfer     = so & ro;
  // Buffer is free now, or it empties on this very edge
  assign can_load = (state == ST_EMPTY) | ((state == ST_HOLD) & ro);
  // Gating with rst keeps clear_o low while reset is held
  assign arb_en   = can_load & rst;
  assign clear_o  = grant;

  rr_arbiter5 u_arb (
    .req       (req_i),
    .last      (last),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Buffer FSM, RR pointer, handshake counter and sticky U-turn flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      datao     <= '0;
      last      <= IDX_PE;
      flit_cnt  <= '0;
      uturn_err <= 1'b0;
    end else begin
      if (|grant) begin
        datao <= slices[grant_idx];
        state <= ST_HOLD;
        last  <= grant_idx;
        if (CHECK_UTURN && (grant_idx == OUT_IDX))
          uturn_err <= 1'b1;
      end else if (xfer) begin
        state <= ST_EMPTY;
      end
      if (xfer)
        flit_cnt <= flit_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_output_ctrl.sv
// Bench for output_ctrl: a PE instance (16-bit counter) and a U-direction
// instance with a 4-bit counter share the same stimulus.
module tb_output_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   req_i;
  logic         ro;
  logic [4:0][63:0] dslice;
  logic [319:0] data_i;

  logic [4:0]   clear0, clear1;
  logic         so0, so1;
  logic [63:0]  datao0, datao1;
  logic         uturn0, uturn1;
  logic [15:0]  cnt0;
  logic [3:0]   cnt1;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb[$];
  logic        m_so;
  logic [15:0] exp_cnt;

  typedef struct {
    logic [4:0] req;
    logic       ro;
    logic [4:0] clr;
    logic       so;
  } vec_t;

  vec_t tbl[13];

  assign data_i = dslice;

  always #5 clk = ~clk;

  output_ctrl #(.DATA_WIDTH(64), .OUT_DIRECTION(5'b00001), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .clear_o(clear0),
    .so(so0), .ro(ro), .datao(datao0), .uturn_err(uturn0), .flit_cnt(cnt0)
  );

  output_ctrl #(.DATA_WIDTH(64), .OUT_DIRECTION(5'b00100), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .clear_o(clear1),
    .so(so1), .ro(ro), .datao(datao1), .uturn_err(uturn1), .flit_cnt(cnt1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus on dut0 with scoreboard tracking of the held flit
  task automatic cyc(input logic [4:0] req, input logic r, input logic [4:0] eclr, input logic eso);
    @(negedge clk);
    req_i = req;
    ro    = r;
    #1;
    chk("clear_o", 64'(clear0), 64'(eclr));
    if (m_so && r) begin
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry");
      end else begin
        void'(sb.pop_front());
      end
      exp_cnt++;
    end
    for (int k = 0; k < 5; k++)
      if (eclr[k]) sb.push_back(dslice[k]);
    @(posedge clk);
    #1;
    m_so = eso;
    chk("so", 64'(so0), 64'(eso));
    if (so0 && sb.size() > 0)
      chk("datao", datao0, sb[0]);
    chk("flit_cnt", 64'(cnt0), 64'(exp_cnt));
  endtask

  // Assert reset with current requests still driven, then release cleanly
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_so", 64'(so0), 64'd0);
    chk("rst_datao", datao0, 64'd0);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    chk("rst_clear", 64'(clear0), 64'd0);
    chk("rst_uturn1", 64'(uturn1), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_so_hold", 64'(so0), 64'd0);
    sb.delete();
    m_so    = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    req_i = '0;
    rst   = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    req_i   = 5'b11111;
    ro      = 1'b1;
    m_so    = 1'b0;
    exp_cnt = '0;
    for (int k = 0; k < 5; k++) dslice[k] = {32'hC0DE_0000, 32'(k)};

    tbl[0]  = '{5'b11111, 1'b1, 5'b00010, 1'b1};
    tbl[1]  = '{5'b11111, 1'b1, 5'b00100, 1'b1};
    tbl[2]  = '{5'b11111, 1'b1, 5'b01000, 1'b1};
    tbl[3]  = '{5'b11111, 1'b1, 5'b10000, 1'b1};
    tbl[4]  = '{5'b11111, 1'b1, 5'b00001, 1'b1};
    tbl[5]  = '{5'b11111, 1'b1, 5'b00010, 1'b1};
    tbl[6]  = '{5'b10001, 1'b0, 5'b00000, 1'b1};
    tbl[7]  = '{5'b10001, 1'b1, 5'b10000, 1'b1};
    tbl[8]  = '{5'b10001, 1'b1, 5'b00001, 1'b1};
    tbl[9]  = '{5'b00000, 1'b1, 5'b00000, 1'b0};
    tbl[10] = '{5'b00000, 1'b1, 5'b00000, 1'b0};
    tbl[11] = '{5'b00001, 1'b0, 5'b00001, 1'b1};
    tbl[12] = '{5'b00000, 1'b1, 5'b00000, 1'b0};

    // Reset state with all inputs requesting
    #1;
    chk("init_so", 64'(so0), 64'd0);
    chk("init_datao", datao0, 64'd0);
    chk("init_cnt", 64'(cnt0), 64'd0);
    chk("init_clear", 64'(clear0), 64'd0);
    chk("init_uturn", 64'(uturn0), 64'd0);
    @(negedge clk);
    req_i = '0;
    rst   = 1'b1;

    // Round-robin order, backpressure and drain patterns
    foreach (tbl[i]) cyc(tbl[i].req, tbl[i].ro, tbl[i].clr, tbl[i].so);
    chk("pe_no_uturn", 64'(uturn0), 64'd0);

    // Single flit from D
    do_reset();
    dslice[1] = 64'hDEAD_BEEF;
    cyc(5'b00010, 1'b1, 5'b00010, 1'b1);
    chk("single_datao", datao0, 64'hDEAD_BEEF);
    cyc(5'b00000, 1'b1, 5'b00000, 1'b0);
    chk("single_cnt", 64'(cnt0), 64'd1);

    // Backpressure: hold four cycles, then drain and refill together
    dslice[3] = 64'h3333_3333_3333_3333;
    cyc(5'b01000, 1'b1, 5'b01000, 1'b1);
    dslice[3] = 64'h4444_4444_4444_4444;
    repeat (4) cyc(5'b01000, 1'b0, 5'b00000, 1'b1);
    chk("bp_stable", datao0, 64'h3333_3333_3333_3333);
    cyc(5'b01000, 1'b1, 5'b01000, 1'b1);
    chk("bp_refill", datao0, 64'h4444_4444_4444_4444);
    chk("bp_cnt", 64'(cnt0), 64'd2);

    // Reset mid-HOLD with R still requesting
    chk("pre_reset_so", 64'(so0), 64'd1);
    req_i = 5'b01000;
    do_reset();

    // U-turn on the U instance and 4-bit counter wrap
    dslice[2] = 64'h0000_0000_0000_0002;
    cyc(5'b00100, 1'b1, 5'b00100, 1'b1);
    chk("uturn_set", 64'(uturn1), 64'd1);
    chk("uturn_fwd_so", 64'(so1), 64'd1);
    chk("uturn_fwd_data", datao1, 64'h2);
    chk("uturn_clear_pe", 64'(uturn0), 64'd0);
    repeat (17) cyc(5'b00100, 1'b1, 5'b00100, 1'b1);
    chk("wrap_cnt4", 64'(cnt1), 64'd1);
    chk("wrap_cnt16", 64'(cnt0), 64'd17);
    cyc(5'b00000, 1'b1, 5'b00000, 1'b0);
    chk("uturn_sticky", 64'(uturn1), 64'd1);
    chk("wrap_cnt4_next", 64'(cnt1), 64'd2);
    chk("uturn_so_drained", 64'(so1), 64'd0);
    do_reset();
    chk("uturn_cleared", 64'(uturn1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_ctrl.md
Name: output_ctrl

Overview:
- Per-output-port stage of the 5-port mesh router, sitting directly downstream of the five input interfaces.
- Each input interface routes its head flit to one output and raises a request. This block does four things:
  - arbitrates round-robin among the five requesters;
  - captures the winner's flit into a one-entry output buffer;
  - returns a one-cycle clear to the winning input so it frees its buffer;
  - drives the so/ro handshake toward the neighbouring router or PE.
- One instance per output direction (L, R, U, D, PE).

Parameters:
- DATA_WIDTH, 64, flit width in bits.
- OUT_DIRECTION, 5'b00001, one-hot code of the output this instance drives (L:10000, R:01000, U:00100, D:00010, PE:00001). Used only for the U-turn check.
- CNT_WIDTH, 16, width of the forwarded-flit counter.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately.
- req_i  input  5  request from each input side for this output; bit4 L, bit3 R, bit2 U, bit1 D, bit0 PE.
- data_i  input  5*DATA_WIDTH  flattened flits; slice k = data_i[k*DATA_WIDTH +: DATA_WIDTH] belongs to req_i[k].
- clear_o  output  5  one-hot grant/clear to the input sides, same bit order; a high bit means the flit was captured at this edge.
- so  output  1  send-out: output buffer holds a valid flit.
- ro  input  1  ready-out: downstream can accept a flit this cycle.
- datao  output  DATA_WIDTH  registered output flit.
- uturn_err  output  1  sticky: set when req_i bit equal to OUT_DIRECTION is ever granted, except for PE.
- flit_cnt  output  CNT_WIDTH  number of flits handed downstream (so&ro edges), wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst=0, async):
  - state=EMPTY, so=0, datao=0, flit_cnt=0, uturn_err=0.
  - RR pointer last=0 (bit0/PE most recently served, so the next search order is 1,2,3,4,0).
  - clear_o=0 while in reset.
  - Reset mid-transfer discards the buffered flit. Inputs keep their requests, since no clear was issued.
- State machine, two states:
  - EMPTY: so=0.
  - HOLD: so=1, datao valid and stable.
- can_load = (state==EMPTY) | (state==HOLD & ro).
- Grant (combinational):
  - If can_load and req_i!=0, grant = first set bit of req_i searching from (last+1) mod 5 upward with wrap. Otherwise grant=0.
  - clear_o = grant. It is asserted only in the cycle whose rising edge captures the flit; the input interface samples clear on that same edge.
- Rising edge with grant!=0:
  - datao <= selected slice, state <= HOLD, last <= granted index.
- Rising edge with so & ro:
  - flit_cnt += 1.
  - If there is no simultaneous grant, state <= EMPTY.
  - Drain and refill in the same cycle is allowed: full throughput of 1 flit/cycle.
- HOLD & !ro: datao and so hold; grant=0; all requests wait with no starvation counter.
- Latency: a request seen in an EMPTY cycle gives so=1 on the next cycle (1-cycle latency).
- Fairness: with all 5 requesting continuously and ro=1, the grant order after reset is 1,2,3,4,0,1,...
- A single requester is regranted every cycle while it keeps requesting (its input reloads).
- uturn_err: set on the edge where grant bit index == index of OUT_DIRECTION, for OUT_DIRECTION != 00001. The flit is still forwarded.
- Requests deasserted before the edge are simply not granted; no other request-retraction rule.

Decomposition:
- Shared package router_pkg holds:
  - direction constants DIR_L/R/U/D/PE (one-hot) and index constants IDX_L=4 .. IDX_PE=0;
  - NUM_PORTS=5;
  - the default flit width.
- Sub-module rr_arbiter5: inputs req[4:0], last[2:0], en; outputs grant[4:0], grant_idx[2:0]. Purely combinational.
- The pointer register stays in output_ctrl.

Test Plan:
- Reset/idle: assert rst=0 mid-HOLD with so=1 -> so=0, datao=0, flit_cnt=0 immediately, and clear_o=0 while in reset.
- Single flit: req_i=00010, slice1=64'hDEAD_BEEF, ro=1 -> clear_o=00010 that cycle; next cycle so=1, datao=DEAD_BEEF; flit_cnt=1 after the following edge.
- Round-robin: req_i=11111 held, ro=1 from reset, distinct data per slice -> grants in order 1,2,3,4,0,1 on consecutive cycles; datao tracks those slices one cycle later.
- Backpressure: buffer HOLD, ro=0 for 4 cycles with req_i=01000 -> clear_o=0, datao stable, so=1. Then ro=1 -> same-cycle drain and capture of R, clear_o=01000, flit_cnt increments once.
- Counter wrap: CNT_WIDTH=4, 17 handshakes -> flit_cnt=1.
- U-turn: OUT_DIRECTION=00100, req_i=00100 -> flit forwarded, uturn_err=1 and it remains 1 until reset.
